// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C requester arbiter/sequencer.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    ADDR,
    XFER,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 4096;

  // A length field of zero encodes the maximum burst.
  localparam logic [4:0] LEN_ZERO_BYTES = 5'd16;

  function automatic logic [4:0] decode_len(input logic [3:0] len);
    return (len == 4'd0) ? LEN_ZERO_BYTES : {1'b0, len};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1, wrapping,
// and returns a one-hot grant (all zero when nothing requests).
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  int          cand;
  logic [PW-1:0] sel;
  logic        found;

  // NOTE: always_comb uses blocking assignments and gives every signal a
  // default first, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = 0;
    sel   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      sel = PW'(cand);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arb_seq.sv
// Arbitrates NREQ requesters onto one I2C master and sequences a single
// address phase plus a write or read burst per grant, with a watchdog.
module i2c_arb_seq
  import i2c_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*4-1:0] req_len,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   grant,
  output logic              wr_pop,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              done,
  output logic              err,
  output logic              m_enable,
  output logic              m_rw,
  output logic              m_restart,
  output logic [6:0]        m_address,
  output logic [7:0]        m_txdata,
  input  logic              m_ready,
  input  logic              m_ack,
  input  logic              m_nack,
  input  logic              m_rxvalid,
  input  logic [7:0]        m_rxdata
);

  localparam int PW = $clog2(NREQ);
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, arb_gnt;
  logic [PW-1:0]   ptr_q, ptr_d, grant_idx;
  logic [6:0]      addr_q, addr_d, win_addr;
  logic            rw_q, rw_d, win_rw;
  logic [3:0]      win_len;
  logic [4:0]      rem_q, rem_d;
  logic [15:0]     wdog_q, wdog_d;
  logic            err_q, err_d;
  logic            rd_valid_q, rd_valid_d;
  logic [7:0]      rd_data_q, rd_data_d, tx_byte;
  logic            master_evt, wdog_active, wdog_expired;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr_arbiter (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Select the arbitration winner's request fields and the granted write byte.
  always_comb begin
    win_addr  = '0;
    win_rw    = 1'b0;
    win_len   = '0;
    tx_byte   = '0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        win_addr = req_addr[i*7 +: 7];
        win_rw   = req_rw[i];
        win_len  = req_len[i*4 +: 4];
      end
      if (grant_q[i]) begin
        tx_byte   = req_wdata[i*8 +: 8];
        grant_idx = PW'(i);
      end
    end
  end

  assign master_evt   = m_ack | m_nack | m_rxvalid;
  assign wdog_active  = state_q inside {START, ADDR, XFER};
  assign wdog_expired = wdog_active && !master_evt && (wdog_q == WDOG_LAST);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    rem_d      = rem_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    m_enable   = 1'b0;
    wr_pop     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      IDLE: if (|req && m_ready) state_d = ARB;
      ARB: begin
        if (|arb_gnt) begin
          grant_d = arb_gnt;
          addr_d  = win_addr;
          rw_d    = win_rw;
          rem_d   = decode_len(win_len);
          err_d   = 1'b0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        m_enable = 1'b1;
        if (wdog_expired) begin
          state_d = DRAIN;
          err_d   = 1'b1;
        end else if (!m_ready) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_enable = 1'b1;
        if (m_nack || wdog_expired) begin
          state_d = DRAIN;
          err_d   = 1'b1;
        end else if (m_ack) begin
          state_d = XFER;
        end
      end
      XFER: begin
        // Drop enable before the final byte so the master stops after it.
        m_enable = (rem_q > 5'd1) && !(m_nack && !rw_q);
        if (rem_q == 5'd0) begin
          state_d = DRAIN;
        end else if (!rw_q && m_nack) begin
          state_d = DRAIN;
          err_d   = 1'b1;
        end else if (!rw_q && m_ack) begin
          wr_pop = 1'b1;
          rem_d  = rem_q - 5'd1;
        end else if (rw_q && m_rxvalid) begin
          rd_valid_d = 1'b1;
          rd_data_d  = m_rxdata;
          rem_d      = rem_q - 5'd1;
        end else if (wdog_expired) begin
          state_d = DRAIN;
          err_d   = 1'b1;
        end
      end
      DRAIN: if (m_ready) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        ptr_d   = grant_idx;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_d != state_q) || master_evt || !wdog_active) wdog_d = '0;
    else                                                    wdog_d = wdog_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= PW'(NREQ - 1);
      addr_q     <= '0;
      rw_q       <= 1'b0;
      rem_q      <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      rem_q      <= rem_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign grant     = grant_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign m_rw      = rw_q;
  assign m_address = addr_q;
  assign m_txdata  = tx_byte;
  assign m_restart = 1'b0;

endmodule

// File: doc/i2c_arb_seq.md
I2C_ARB_SEQ -- requirements
Module: i2c_arb_seq

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 4096: idle clk cycles allowed between master events before abort.
REQ-003 SHALL have ports clk in 1 (clock) and reset_n in 1 (asynchronous, active-low reset).
REQ-004 SHALL have ports req in NREQ (request level per requester, held until its done pulse).
REQ-005 SHALL have ports req_addr in NREQ*7, req_rw in NREQ and req_len in NREQ*4 (per-requester target address, 1=read, byte count with 0 meaning 16).
REQ-006 SHALL have port req_wdata in NREQ*8: current write byte per requester.
REQ-007 SHALL have ports grant out NREQ (one-hot) and wr_pop out 1 (write byte consumed).
REQ-008 SHALL have ports rd_valid out 1 and rd_data out 8 (read byte strobe and data, for the granted requester).
REQ-009 SHALL have ports done out 1 and err out 1 (end-of-transaction pulse; err is valid with done).
REQ-010 SHALL have master-side outputs m_enable 1, m_rw 1, m_restart 1, m_address 7 and m_txdata 8.
REQ-011 SHALL have master-side inputs m_ready 1 (master idle), m_ack 1 (1-cycle pulse per ACKed address/data byte), m_nack 1 (1-cycle pulse on NACK), m_rxvalid 1 (1-cycle pulse, new m_rxdata) and m_rxdata 8.

Function
REQ-012 SHALL implement FSM states IDLE, ARB, START, ADDR, XFER, DRAIN and DONE.
REQ-013 IDLE SHALL move to ARB when any req is high and m_ready=1; otherwise it SHALL stay in IDLE.
REQ-014 ARB SHALL register a round-robin one-hot grant, searching upward from the index after the last winner (pointer reset = NREQ-1, so requester 0 has first priority), and SHALL latch addr, rw and len into local registers.
REQ-015 grant SHALL hold constant from ARB exit until the DONE cycle inclusive, with at most one bit set.
REQ-016 START SHALL assert m_enable with m_address, m_rw and m_txdata driven from the latched/granted values, and SHALL move to ADDR when m_ready falls.
REQ-017 ADDR: m_ack SHALL go to XFER; m_nack SHALL go to DRAIN with err set.
REQ-018 XFER write: each m_ack SHALL pulse wr_pop in the same cycle and decrement the remaining count.
REQ-019 XFER read: each m_rxvalid SHALL drive rd_valid=1 and rd_data=m_rxdata in the next cycle and decrement the remaining count.
REQ-020 m_enable SHALL be low once remaining<=1 during XFER, so the master stops after the last byte; remaining=0 SHALL go to DRAIN.
REQ-021 A write-byte m_nack in XFER SHALL go to DRAIN with err set and drop m_enable; the remaining bytes are abandoned.
REQ-022 DRAIN SHALL hold m_enable=0 and wait for m_ready=1, then go to DONE.
REQ-023 DONE SHALL pulse done for 1 cycle, update the RR pointer, clear grant and return to IDLE.
REQ-024 A 16-bit watchdog SHALL clear on every state change, m_ack, m_nack or m_rxvalid; reaching TIMEOUT in START, ADDR or XFER SHALL go to DRAIN with err set.
REQ-025 m_restart SHALL be driven 0 (reserved for combined transactions).
REQ-026 A req dropped while granted SHALL be ignored until DONE: no mid-transaction cancel.
REQ-027 When new requests arrive simultaneously with DONE, they SHALL be arbitrated in the next ARB, never in the same cycle.

Reset
REQ-028 reset_n low SHALL force IDLE, grant=0, m_enable=0, wr_pop=rd_valid=done=err=0, RR pointer=NREQ-1, watchdog=0, remaining=0.
REQ-029 Reset mid-transaction SHALL drop m_enable immediately and SHALL emit no done pulse.

Structure
REQ-030 The state enum, the TIMEOUT default and the len-0=16 decode constant SHALL live in package i2c_pkg.
REQ-031 The round-robin arbiter SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot gnt).

Verification
REQ-032 Case: req=0001, write, addr 0x50, len 2, 2 acks -> wr_pop x2, m_enable low after 1st data ack, done=1 err=0.
REQ-033 Case: req=1111 held for 4 transactions -> grant order 0001, 0010, 0100, 1000.
REQ-034 Case: read len 3, rxdata A1, B2, C3 -> rd_valid x3 with those values, then done.
REQ-035 Case: address NACK -> no wr_pop, wait m_ready, done=1 err=1.
REQ-036 Case: TIMEOUT=16, no master response after START -> done with err=1 at cycle 16+drain.
REQ-037 Case: reset asserted in XFER -> m_enable=0 and grant=0 immediately, then the next transaction starts from requester 0.
